// File: rtl/fixed_point_mac_accumulator.sv
// fixed_point_mac_accumulator: sign-magnitude Q-format dot-product accumulator with saturating valid/ready output.
// Define FIXED_POINT_MAC_RELU_EN to clamp negative results to zero after saturation.
module fixed_point_mac_accumulator #(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int ACC_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] bias,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_of,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_of
);
  typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;
  localparam logic signed [ACC_W-1:0] P_MAX = ACC_W'((1 << (N-1)) - 1);
  localparam logic signed [ACC_W-1:0] P_MIN = -P_MAX;
  if (Q >= N-1 || ACC_W < N+8) begin : g_bad_cfg
    $error("fixed_point_mac_accumulator: Q must leave an integer bit and ACC_W must cover 255 terms");
  end
  state_t                  r_state, w_next;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_of, r_out_valid, r_out_of;
  logic        [N-1:0]     r_out_data;
  logic                    w_accept, w_pos_sat, w_neg_sat, w_sat, w_neg;
  logic        [N-2:0]     w_mag;
  logic        [N-1:0]     w_sm, w_res;
  function automatic logic signed [ACC_W-1:0] ext(input logic [N-1:0] x);
    logic [ACC_W-1:0] m;
    m = ACC_W'(x[N-2:0]);
    return $signed(x[N-1] ? -m : m);
  endfunction
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = (r_state == IDLE || r_state == ACCUM) ? (w_accept ? (in_last ? SAT : ACCUM) : r_state)
           : (r_state == SAT) ? OUT
           : (out_ready ? IDLE : OUT);
  end
  always_comb begin
    in_ready = (r_state == IDLE) || (r_state == ACCUM);
  end
  assign w_accept  = in_valid & in_ready;
  assign w_pos_sat = r_acc > P_MAX;
  assign w_neg_sat = r_acc < P_MIN;
  assign w_sat     = w_pos_sat | w_neg_sat;
  assign w_neg     = r_acc[ACC_W-1];
  // In-range values fit in N-1 bits, so negating only the low bits yields the exact magnitude.
  assign w_mag     = w_neg ? -r_acc[N-2:0] : r_acc[N-2:0];
  assign w_sm      = w_pos_sat ? {1'b0, {(N-1){1'b1}}}
                   : w_neg_sat ? {1'b1, {(N-1){1'b1}}}
                   : {w_neg & (|w_mag), w_mag};
`ifdef FIXED_POINT_MAC_RELU_EN
  assign w_res = w_neg ? '0 : w_sm;
`else
  assign w_res = w_sm;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_of        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_of    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= (r_state == IDLE ? ext(bias) : r_acc) + ext(in_data);
        r_of  <= (r_state == ACCUM && r_of) | in_of;
      end
      if (r_state == SAT) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_of    <= r_of | w_sat;
      end
      if (r_state == OUT && out_ready) begin
        r_out_valid <= 1'b0;
        r_acc       <= '0;
      end
    end
  end
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_of    = r_out_of;
endmodule

// File: tb/tb_fixed_point_mac_accumulator.sv
// tb_fixed_point_mac_accumulator: directed vectors for the MAC accumulator with hand-computed results.
module tb_fixed_point_mac_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_of = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_of;
  int          n_chk = 0;
  int          n_err = 0;
  fixed_point_mac_accumulator dut (
    .clk(clk), .rst(rst), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_of(in_of), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_of(out_of)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [15:0] d, input logic of, input logic last);
    chk("in_ready_before_beat", 32'(in_ready), 1);
    in_data  = d;
    in_of    = of;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_of    = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic [15:0] d, input logic of, input int hold);
    chk({tag, "_sat_no_valid"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_of"}, 32'(out_of), 32'(of));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1000;
      tick();
      chk({tag, "_hold_valid"}, 32'(out_valid), 1);
      chk({tag, "_hold_data"}, 32'(out_data), 32'(d));
      chk({tag, "_hold_rdy"}, 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 0);
    chk({tag, "_idle_rdy"}, 32'(in_ready), 1);
  endtask
  initial begin
    logic [15:0] e_neg_small, e_neg_sat;
`ifdef FIXED_POINT_MAC_RELU_EN
    e_neg_small = 16'h0000;
    e_neg_sat   = 16'h0000;
`else
    e_neg_small = 16'h9000;
    e_neg_sat   = 16'hFFFF;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_of", 32'(out_of), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    bias = 16'h0000;
    put(16'h1000, 0, 0);
    put(16'h1000, 0, 0);
    put(16'h1000, 0, 1);
    expect_out("sum3", 16'h3000, 0, 0);
    bias = 16'h8800;
    put(16'h1000, 0, 0);
    put(16'h9800, 0, 1);
    expect_out("neg", e_neg_small, 0, 0);
    bias = 16'h0000;
    for (int i = 0; i < 9; i++) put(16'h7000, 0, i == 8);
    expect_out("pos_sat", 16'h7FFF, 1, 0);
    for (int i = 0; i < 9; i++) put(16'hF000, 0, i == 8);
    expect_out("neg_sat", e_neg_sat, 1, 0);
    put(16'h0100, 1, 1);
    expect_out("single_of", 16'h0100, 1, 0);
    put(16'h0100, 0, 1);
    expect_out("sticky_clr", 16'h0100, 0, 0);
    bias = 16'h8000;
    put(16'h8000, 0, 1);
    expect_out("neg_zero", 16'h0000, 0, 0);
    bias = 16'h0000;
    put(16'h0400, 0, 0);
    put(16'h0400, 0, 1);
    expect_out("hold5", 16'h0800, 0, 5);
    put(16'h1000, 0, 0);
    put(16'h1000, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_rdy", 32'(in_ready), 1);
    tick();
    tick();
    chk("midrst_no_out", 32'(out_valid), 0);
    put(16'h0800, 0, 1);
    expect_out("after_rst", 16'h0800, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
